// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with a per-entry busy scoreboard.
// NUM_RD combinational read ports and two write ports. On a same-address collision,
// write port B (late/load return) wins over port A (WB stage).
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through from the write ports to the read ports.
module reg_file_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int SP_IDX   = 29,
    parameter int SP_INIT  = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_RD*AW-1:0] rs_addr_i,
    output logic [NUM_RD*DW-1:0] rs_data_o,
    output logic [NUM_RD-1:0]    rs_busy_o,
    input  logic                 wa_en_i,
    input  logic [AW-1:0]        wa_addr_i,
    input  logic [DW-1:0]        wa_data_i,
    input  logic                 wa_clr_i,
    input  logic                 wb_en_i,
    input  logic [AW-1:0]        wb_addr_i,
    input  logic [DW-1:0]        wb_data_i,
    input  logic                 wb_clr_i,
    input  logic                 alloc_en_i,
    input  logic [AW-1:0]        alloc_addr_i,
    output logic [AW:0]          busy_cnt_o
);
    localparam int DEPTH = 2**AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // Next scoreboard state. A clear is applied first, so a same-cycle alloc (new producer) wins.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if ((wa_en_i && wa_clr_i && wa_addr_i == AW'(i)) ||
                (wb_en_i && wb_clr_i && wb_addr_i == AW'(i)))
                busy_nxt[i] = 1'b0;
            if (alloc_en_i && alloc_addr_i == AW'(i))
                busy_nxt[i] = 1'b1;
            if (ZERO_REG != 0 && i == 0)
                busy_nxt[i] = 1'b0;
        end
    end

    // Popcount of the next busy vector. It is registered alongside the busy bits.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end

    // Array and scoreboard state. Reset restores the stack pointer and overrides all writes and allocs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (i == SP_IDX) ? DW'(SP_INIT) : '0;
            busy       <= '0;
            busy_cnt_o <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(ZERO_REG != 0 && i == 0)) begin
                    if (wb_en_i && wb_addr_i == AW'(i))
                        mem[i] <= wb_data_i;
                    else if (wa_en_i && wa_addr_i == AW'(i))
                        mem[i] <= wa_data_i;
                end
            end
            busy       <= busy_nxt;
            busy_cnt_o <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          rb;
        assign ra = rs_addr_i[k*AW +: AW];

        // Combinational read. The optional bypass applies B before A, and entry 0 is forced last.
        always_comb begin
            rd = mem[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (wb_en_i && wb_addr_i == ra) begin
                rd = wb_data_i;
                if (wb_clr_i && !(alloc_en_i && alloc_addr_i == ra)) rb = 1'b0;
            end else if (wa_en_i && wa_addr_i == ra) begin
                rd = wa_data_i;
                if (wa_clr_i && !(alloc_en_i && alloc_addr_i == ra)) rb = 1'b0;
            end
`endif
            if (ZERO_REG != 0 && ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rs_data_o[k*DW +: DW] = rd;
        assign rs_busy_o[k]          = rb;
    end

`ifndef SYNTHESIS
    // Simulation checks: port-count range, and a clearing write that lands on an entry that is already free.
    always @(posedge clk_i) begin
        assert (NUM_RD >= 1 && NUM_RD <= 4) else $error("reg_file_mp: NUM_RD=%0d out of range", NUM_RD);
        if (!rst_i && wa_en_i && wa_clr_i && !busy[wa_addr_i] && !(ZERO_REG != 0 && wa_addr_i == '0))
            $warning("reg_file_mp: port A clears free entry %0d", wa_addr_i);
        if (!rst_i && wb_en_i && wb_clr_i && !busy[wb_addr_i] && !(ZERO_REG != 0 && wb_addr_i == '0))
            $warning("reg_file_mp: port B clears free entry %0d", wb_addr_i);
    end
`endif
endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp with the default parameters (DW=32, AW=5, NUM_RD=2).
module tb_reg_file_mp;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  rs_addr_i;
    logic [63:0] rs_data_o;
    logic [1:0]  rs_busy_o;
    logic        wa_en_i, wa_clr_i, wb_en_i, wb_clr_i, alloc_en_i;
    logic [4:0]  wa_addr_i, wb_addr_i, alloc_addr_i;
    logic [31:0] wa_data_i, wb_data_i;
    logic [5:0]  busy_cnt_o;

    int tests = 0;
    int fails = 0;

    reg_file_mp dut (
        .clk_i(clk_i), .rst_i(rst_i), .rs_addr_i(rs_addr_i), .rs_data_o(rs_data_o),
        .rs_busy_o(rs_busy_o), .wa_en_i(wa_en_i), .wa_addr_i(wa_addr_i), .wa_data_i(wa_data_i),
        .wa_clr_i(wa_clr_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .wb_clr_i(wb_clr_i), .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i),
        .busy_cnt_o(busy_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: register values and the set of busy entries.
    logic [31:0] mdata [32];
    logic        mbusy [32];

    typedef struct {
        logic rst;
        logic wa_en; logic [4:0] wa_addr; logic [31:0] wa_data; logic wa_clr;
        logic wb_en; logic [4:0] wb_addr; logic [31:0] wb_data; logic wb_clr;
        logic al_en; logic [4:0] al_addr;
        logic [4:0] r0; logic [4:0] r1;
        logic [31:0] e0; logic [31:0] e1;
        logic eb0; logic eb1; logic [5:0] ecnt;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst_i = 0; wa_en_i = 0; wa_clr_i = 0; wb_en_i = 0; wb_clr_i = 0; alloc_en_i = 0;
        wa_addr_i = 0; wb_addr_i = 0; alloc_addr_i = 0; wa_data_i = 0; wb_data_i = 0;
    endtask

    // Expected read result for one address, derived from the model state and the current inputs.
    task automatic exp_rd(input logic [4:0] r, output logic [31:0] d, output logic b);
        d = mdata[r];
        b = mbusy[r];
`ifdef REGFILE_BYPASS_EN
        if (wb_en_i && wb_addr_i == r) begin
            d = wb_data_i;
            if (wb_clr_i && !(alloc_en_i && alloc_addr_i == r)) b = 0;
        end else if (wa_en_i && wa_addr_i == r) begin
            d = wa_data_i;
            if (wa_clr_i && !(alloc_en_i && alloc_addr_i == r)) b = 0;
        end
`endif
        if (r == 0) begin d = 0; b = 0; end
    endtask

    // Update the model from the inputs that were sampled at the clock edge.
    task automatic model_edge();
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin mdata[i] = 0; mbusy[i] = 0; end
            mdata[29] = 128;
        end else begin
            if (wa_en_i && wa_addr_i != 0) mdata[wa_addr_i] = wa_data_i;
            if (wb_en_i && wb_addr_i != 0) mdata[wb_addr_i] = wb_data_i;
            if (wa_en_i && wa_clr_i) mbusy[wa_addr_i] = 0;
            if (wb_en_i && wb_clr_i) mbusy[wb_addr_i] = 0;
            if (alloc_en_i && alloc_addr_i != 0) mbusy[alloc_addr_i] = 1;
        end
    endtask

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] ed0, ed1;
        logic        eb0, eb1;
        idle();
        rs_addr_i = 0;

        //             rst wa_en addr data         clr wb_en addr data         clr al  aa  r0  r1  e0            e1           b0 b1 cnt
        tbl[0] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 5'd0, 5'd29, 32'h0,        32'd128,     1'b0, 1'b0, 6'd0};
        tbl[1] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 5'd5, 5'd29, 32'hDEADBEEF, 32'd128,     1'b0, 1'b0, 6'd0};
        tbl[2] = '{1'b0, 1'b1, 5'd7, 32'h11,       1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 1'b0, 5'd0, 5'd7, 5'd5,  32'h22,       32'hDEADBEEF,1'b0, 1'b0, 6'd0};
        tbl[3] = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd0, 5'd0, 5'd7,  32'h0,        32'h22,      1'b0, 1'b0, 6'd0};
        tbl[4] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd3, 5'd3, 5'd0,  32'h0,        32'h0,       1'b1, 1'b0, 6'd1};
        tbl[5] = '{1'b0, 1'b1, 5'd3, 32'hAA,       1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd3, 5'd3, 5'd0,  32'hAA,       32'h0,       1'b1, 1'b0, 6'd1};
        tbl[6] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 32'hBB, 1'b1, 1'b0, 5'd0, 5'd3, 5'd0,  32'hBB,       32'h0,       1'b0, 1'b0, 6'd0};
        tbl[7] = '{1'b0, 1'b1, 5'd9, 32'h99,       1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0,  32'h99,       32'h0,       1'b0, 1'b0, 6'd0};

        // Directed table: apply one cycle of inputs, then check the state after the edge.
        for (int v = 0; v < 8; v++) begin
            rst_i = tbl[v].rst;
            wa_en_i = tbl[v].wa_en; wa_addr_i = tbl[v].wa_addr; wa_data_i = tbl[v].wa_data; wa_clr_i = tbl[v].wa_clr;
            wb_en_i = tbl[v].wb_en; wb_addr_i = tbl[v].wb_addr; wb_data_i = tbl[v].wb_data; wb_clr_i = tbl[v].wb_clr;
            alloc_en_i = tbl[v].al_en; alloc_addr_i = tbl[v].al_addr;
            rs_addr_i = {tbl[v].r1, tbl[v].r0};
            tick();
            idle();
            #1;
            chk($sformatf("vec%0d data0", v), 64'(rs_data_o[31:0]),  64'(tbl[v].e0));
            chk($sformatf("vec%0d data1", v), 64'(rs_data_o[63:32]), 64'(tbl[v].e1));
            chk($sformatf("vec%0d busy", v),  64'(rs_busy_o), 64'({tbl[v].eb1, tbl[v].eb0}));
            chk($sformatf("vec%0d cnt", v),   64'(busy_cnt_o), 64'(tbl[v].ecnt));
        end

`ifdef REGFILE_BYPASS_EN
        // Write-through: the data is visible in the same cycle as the write.
        wa_en_i = 1; wa_addr_i = 5'd12; wa_data_i = 32'hC0FFEE00; rs_addr_i = {5'd0, 5'd12};
        #1;
        chk("bypass same cycle", 64'(rs_data_o[31:0]), 64'h00000000C0FFEE00);
        tick();
        idle();
`endif

        // Alloc 1..10, one per cycle, with reset asserted on the sixth cycle.
        for (int c = 1; c <= 10; c++) begin
            alloc_en_i = 1; alloc_addr_i = 5'(c); rst_i = (c == 6);
            tick();
            if (c == 6) begin
                rs_addr_i = {5'd5, 5'd1};
                #1;
                chk("alloc/rst cnt", 64'(busy_cnt_o), 64'd0);
                chk("alloc/rst busy", 64'(rs_busy_o), 64'd0);
            end
        end
        idle();
        rs_addr_i = {5'd10, 5'd7};
        #1;
        chk("alloc 7..10 cnt", 64'(busy_cnt_o), 64'd4);
        chk("alloc 7..10 busy", 64'(rs_busy_o), 64'd3);

        // Randomized run against the model. The first cycle resets both the DUT and the model.
        for (int n = 0; n < 400; n++) begin
            rst_i = (n == 0) || ($urandom_range(0, 63) == 0);
            wa_en_i = 1'($urandom); wa_addr_i = 5'($urandom); wa_data_i = $urandom;
            wb_en_i = 1'($urandom); wb_addr_i = 5'($urandom); wb_data_i = $urandom;
            wa_clr_i = (n > 0) && wa_en_i && 1'($urandom) && mbusy[wa_addr_i];
            wb_clr_i = (n > 0) && wb_en_i && 1'($urandom) && mbusy[wb_addr_i];
            alloc_en_i = 1'($urandom); alloc_addr_i = 5'($urandom);
            rs_addr_i = {5'($urandom), 5'($urandom)};
            #1;
            if (n > 0) begin
                exp_rd(rs_addr_i[4:0], ed0, eb0);
                exp_rd(rs_addr_i[9:5], ed1, eb1);
                chk("rand data0", 64'(rs_data_o[31:0]),  64'(ed0));
                chk("rand data1", 64'(rs_data_o[63:32]), 64'(ed1));
                chk("rand busy",  64'(rs_busy_o), 64'({eb1, eb0}));
            end
            @(posedge clk_i);
            model_edge();
            #1;
            chk("rand cnt", 64'(busy_cnt_o), 64'(mcount()));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
